// File: rtl/renaming_map_ckpt.sv
// Register-renaming map with a bit-vector free list and a FIFO of map/free-list
// checkpoints for branch rollback. One rename per cycle, one-cycle output latency.
module renaming_map_ckpt #(
  parameter int ARCH_REG_WIDTH = 5,
  parameter int PHYS_REG_WIDTH = 6,
  parameter int NR_CKPT        = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  logic [ARCH_REG_WIDTH-1:0]   in_rd_i,
  input  logic [ARCH_REG_WIDTH-1:0]   in_rs1_i,
  input  logic [ARCH_REG_WIDTH-1:0]   in_rs2_i,
  input  logic                        in_ckpt_i,
  output logic                        out_valid_o,
  output logic [PHYS_REG_WIDTH-1:0]   out_rd_o,
  output logic [PHYS_REG_WIDTH-1:0]   out_rs1_o,
  output logic [PHYS_REG_WIDTH-1:0]   out_rs2_o,
  output logic [PHYS_REG_WIDTH-1:0]   out_prev_rd_o,
  output logic [$clog2(NR_CKPT)-1:0]  out_ckpt_id_o,
  input  logic                        commit_valid_i,
  input  logic [PHYS_REG_WIDTH-1:0]   commit_preg_i,
  input  logic                        restore_i,
  input  logic [$clog2(NR_CKPT)-1:0]  restore_id_i,
  input  logic                        release_i,
  output logic                        ckpt_full_o,
  output logic [PHYS_REG_WIDTH:0]     free_count_o
);
  localparam int NR_ARCH = 1 << ARCH_REG_WIDTH;
  localparam int NR_PHYS = 1 << PHYS_REG_WIDTH;
  localparam int CW      = $clog2(NR_CKPT);
  localparam int PW      = PHYS_REG_WIDTH;

  typedef logic [NR_ARCH-1:0][PW-1:0] map_t;

  map_t               map_q, map_d;
  logic [NR_PHYS-1:0] free_q, free_d;
  map_t               ckpt_map_q  [NR_CKPT];
  map_t               ckpt_map_d  [NR_CKPT];
  logic [NR_PHYS-1:0] ckpt_free_q [NR_CKPT];
  logic [NR_PHYS-1:0] ckpt_free_d [NR_CKPT];
  logic [CW-1:0]      head_q, head_d, tail_q, tail_d;
  logic [CW:0]        count_q, count_d;
  logic [PW:0]        free_count_q, free_count_d;

  logic               out_valid_q, out_valid_d;
  logic [PW-1:0]      out_rd_q, out_rd_d, out_rs1_q, out_rs1_d;
  logic [PW-1:0]      out_rs2_q, out_rs2_d, out_prev_q, out_prev_d;
  logic [CW-1:0]      out_ckpt_id_q, out_ckpt_id_d;

  logic               rd_nz, have_free, full, fire, take, rel, commit_en;
  logic [PW-1:0]      alloc_idx;
  logic [NR_PHYS-1:0] commit_vec;
  logic [CW-1:0]      off, diff;

  always_comb begin
    // Lowest-index free register; pr0 is never free so the scan stops at 1.
    alloc_idx = '0;
    for (int i = NR_PHYS - 1; i >= 1; i--) begin
      if (free_q[i]) alloc_idx = PW'(i);
    end
    have_free  = |free_q;
    rd_nz      = (in_rd_i != '0);
    full       = (count_q == (CW+1)'(NR_CKPT));
    in_ready_o = !restore_i && (!rd_nz || have_free) && (!in_ckpt_i || !full);
    fire       = in_valid_i && in_ready_o;
    take       = fire && in_ckpt_i;
    rel        = release_i && (count_q != '0);
    commit_en  = commit_valid_i && (commit_preg_i != '0);
    commit_vec = '0;
    if (commit_en) commit_vec[commit_preg_i] = 1'b1;

    map_d         = map_q;
    free_d        = free_q;
    out_valid_d   = 1'b0;
    out_rd_d      = out_rd_q;
    out_rs1_d     = out_rs1_q;
    out_rs2_d     = out_rs2_q;
    out_prev_d    = out_prev_q;
    out_ckpt_id_d = out_ckpt_id_q;
    if (fire) begin
      out_valid_d   = 1'b1;
      out_rs1_d     = map_q[in_rs1_i];
      out_rs2_d     = map_q[in_rs2_i];
      out_rd_d      = '0;
      out_prev_d    = '0;
      out_ckpt_id_d = in_ckpt_i ? tail_q : '0;
      if (rd_nz) begin
        out_rd_d          = alloc_idx;
        out_prev_d        = map_q[in_rd_i];
        map_d[in_rd_i]    = alloc_idx;
        free_d[alloc_idx] = 1'b0;
      end
    end
    free_d = free_d | commit_vec;

    // Commits must also reach live snapshots so a rollback cannot leak them.
    ckpt_map_d  = ckpt_map_q;
    ckpt_free_d = ckpt_free_q;
    for (int i = 0; i < NR_CKPT; i++) begin
      off = CW'(i) - head_q;
      if ({1'b0, off} < count_q) ckpt_free_d[i] = ckpt_free_q[i] | commit_vec;
    end
    if (take) begin
      ckpt_map_d[tail_q]  = map_d;
      ckpt_free_d[tail_q] = free_d;
    end

    head_d  = rel ? head_q + CW'(1) : head_q;
    tail_d  = tail_q;
    count_d = count_q;
    diff    = '0;
    if (restore_i) begin
      map_d  = ckpt_map_q[restore_id_i];
      free_d = ckpt_free_q[restore_id_i] | commit_vec;
      tail_d = restore_id_i + CW'(1);
      diff   = tail_d - head_d;
      // The restored slot stays live, so equal pointers mean a full FIFO.
      count_d = (diff == '0) ? (CW+1)'(NR_CKPT) : {1'b0, diff};
    end else begin
      if (take) tail_d = tail_q + CW'(1);
      count_d = count_q + (CW+1)'(take) - (CW+1)'(rel);
    end

    free_count_d = '0;
    for (int i = 0; i < NR_PHYS; i++) begin
      free_count_d = free_count_d + (PW+1)'(free_d[i]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NR_ARCH; i++) map_q[i] <= PW'(i);
      for (int i = 0; i < NR_PHYS; i++) free_q[i] <= (i >= NR_ARCH);
      for (int i = 0; i < NR_CKPT; i++) begin
        ckpt_map_q[i]  <= '0;
        ckpt_free_q[i] <= '0;
      end
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      free_count_q  <= (PW+1)'(NR_PHYS - NR_ARCH);
      out_valid_q   <= 1'b0;
      out_rd_q      <= '0;
      out_rs1_q     <= '0;
      out_rs2_q     <= '0;
      out_prev_q    <= '0;
      out_ckpt_id_q <= '0;
    end else begin
      map_q         <= map_d;
      free_q        <= free_d;
      ckpt_map_q    <= ckpt_map_d;
      ckpt_free_q   <= ckpt_free_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      free_count_q  <= free_count_d;
      out_valid_q   <= out_valid_d;
      out_rd_q      <= out_rd_d;
      out_rs1_q     <= out_rs1_d;
      out_rs2_q     <= out_rs2_d;
      out_prev_q    <= out_prev_d;
      out_ckpt_id_q <= out_ckpt_id_d;
    end
  end

  assign out_valid_o   = out_valid_q;
  assign out_rd_o      = out_rd_q;
  assign out_rs1_o     = out_rs1_q;
  assign out_rs2_o     = out_rs2_q;
  assign out_prev_rd_o = out_prev_q;
  assign out_ckpt_id_o = out_ckpt_id_q;
  assign ckpt_full_o   = (count_q == (CW+1)'(NR_CKPT));
  assign free_count_o  = free_count_q;
endmodule

// File: tb/tb_renaming_map_ckpt.sv
// Directed bench for renaming_map_ckpt at default parameters: rename, back-to-back
// dependences, free-list exhaustion, rollback, commit/restore interplay, FIFO wrap.
module tb_renaming_map_ckpt;
  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       in_valid_i, in_ready_o, in_ckpt_i;
  logic [4:0] in_rd_i, in_rs1_i, in_rs2_i;
  logic       out_valid_o;
  logic [5:0] out_rd_o, out_rs1_o, out_rs2_o, out_prev_rd_o;
  logic [1:0] out_ckpt_id_o;
  logic       commit_valid_i;
  logic [5:0] commit_preg_i;
  logic       restore_i, release_i, ckpt_full_o;
  logic [1:0] restore_id_i;
  logic [6:0] free_count_o;

  int checks = 0;
  int errors = 0;

  // Bookkeeping of live checkpoint slots, used only to guard restore legality.
  logic [3:0] live;
  logic [1:0] head_m, tail_m;

  renaming_map_ckpt dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_rd_i(in_rd_i), .in_rs1_i(in_rs1_i), .in_rs2_i(in_rs2_i), .in_ckpt_i(in_ckpt_i),
    .out_valid_o(out_valid_o), .out_rd_o(out_rd_o), .out_rs1_o(out_rs1_o),
    .out_rs2_o(out_rs2_o), .out_prev_rd_o(out_prev_rd_o), .out_ckpt_id_o(out_ckpt_id_o),
    .commit_valid_i(commit_valid_i), .commit_preg_i(commit_preg_i),
    .restore_i(restore_i), .restore_id_i(restore_id_i), .release_i(release_i),
    .ckpt_full_o(ckpt_full_o), .free_count_o(free_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic clear_inputs();
    in_valid_i = 0; in_ckpt_i = 0; in_rd_i = 0; in_rs1_i = 0; in_rs2_i = 0;
    commit_valid_i = 0; commit_preg_i = 0; restore_i = 0; restore_id_i = 0; release_i = 0;
  endtask

  task automatic do_reset();
    rst_i = 1; clear_inputs();
    repeat (2) @(posedge clk_i);
    #1 rst_i = 0;
    live = 0; head_m = 0; tail_m = 0;
  endtask

  task automatic rename(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic ck);
    in_valid_i = 1; in_rd_i = rd; in_rs1_i = rs1; in_rs2_i = rs2; in_ckpt_i = ck;
    if (ck && in_ready_o) begin live[tail_m] = 1'b1; tail_m = tail_m + 2'd1; end
    @(posedge clk_i); #1;
    in_valid_i = 0; in_ckpt_i = 0;
  endtask

  task automatic commit(input logic [5:0] p);
    commit_valid_i = 1; commit_preg_i = p;
    @(posedge clk_i); #1;
    commit_valid_i = 0;
  endtask

  task automatic do_release();
    release_i = 1;
    if (live[head_m]) begin live[head_m] = 1'b0; head_m = head_m + 2'd1; end
    @(posedge clk_i); #1;
    release_i = 0;
  endtask

  // Optional same-cycle commit of pr cp (0 = none).
  task automatic do_restore(input logic [1:0] id, input logic [5:0] cp);
    if (!live[id]) begin
      $display("FAIL restore_legal slot %0d is not live", id);
      $fatal(1, "illegal restore");
    end
    restore_i = 1; restore_id_i = id;
    commit_valid_i = (cp != 0); commit_preg_i = cp;
    tail_m = id + 2'd1;
    for (int i = 0; i < 4; i++) if ((2'(i) - head_m) > (id - head_m)) live[i] = 1'b0;
    @(posedge clk_i); #1;
    restore_i = 0; commit_valid_i = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0d exp 0", out_valid_o); end
    checks++; if (out_rd_o !== 6'd0 || out_prev_rd_o !== 6'd0 || out_ckpt_id_o !== 2'd0) begin
      errors++; $display("FAIL reset_outs got rd=%0d prev=%0d id=%0d exp 0", out_rd_o, out_prev_rd_o, out_ckpt_id_o); end
    checks++; if (free_count_o !== 7'd32) begin errors++; $display("FAIL reset_free_count got %0d exp 32", free_count_o); end
    checks++; if (ckpt_full_o !== 1'b0) begin errors++; $display("FAIL reset_ckpt_full got %0d exp 0", ckpt_full_o); end
    checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0d exp 1", in_ready_o); end
  endtask

  task automatic test_basic();
    do_reset();
    rename(5'd7, 5'd3, 5'd0, 1'b0);
    checks++; if (out_valid_o !== 1'b1) begin errors++; $display("FAIL basic_valid got %0d exp 1", out_valid_o); end
    checks++; if (out_rd_o !== 6'd32 || out_rs1_o !== 6'd3 || out_rs2_o !== 6'd0 || out_prev_rd_o !== 6'd7) begin
      errors++; $display("FAIL basic_regs got rd=%0d rs1=%0d rs2=%0d prev=%0d exp 32 3 0 7",
                         out_rd_o, out_rs1_o, out_rs2_o, out_prev_rd_o); end
    checks++; if (free_count_o !== 7'd31) begin errors++; $display("FAIL basic_free_count got %0d exp 31", free_count_o); end
    @(posedge clk_i); #1;
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL basic_valid_pulse got %0d exp 0", out_valid_o); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    rename(5'd7, 5'd0, 5'd0, 1'b0);
    rename(5'd6, 5'd7, 5'd11, 1'b0);
    checks++; if (out_rd_o !== 6'd33 || out_rs1_o !== 6'd32 || out_rs2_o !== 6'd11 || out_prev_rd_o !== 6'd6) begin
      errors++; $display("FAIL b2b_regs got rd=%0d rs1=%0d rs2=%0d prev=%0d exp 33 32 11 6",
                         out_rd_o, out_rs1_o, out_rs2_o, out_prev_rd_o); end
    rename(5'd0, 5'd6, 5'd0, 1'b0);
    checks++; if (out_valid_o !== 1'b1 || out_rd_o !== 6'd0 || out_prev_rd_o !== 6'd0 || out_rs1_o !== 6'd33) begin
      errors++; $display("FAIL rd0_regs got v=%0d rd=%0d prev=%0d rs1=%0d exp 1 0 0 33",
                         out_valid_o, out_rd_o, out_prev_rd_o, out_rs1_o); end
    checks++; if (free_count_o !== 7'd30) begin errors++; $display("FAIL rd0_free_count got %0d exp 30", free_count_o); end
  endtask

  task automatic test_exhaust();
    do_reset();
    for (int i = 0; i < 32; i++) rename(5'((i % 31) + 1), 5'd0, 5'd0, 1'b0);
    checks++; if (out_rd_o !== 6'd63) begin errors++; $display("FAIL exhaust_last got %0d exp 63", out_rd_o); end
    checks++; if (free_count_o !== 7'd0) begin errors++; $display("FAIL exhaust_free_count got %0d exp 0", free_count_o); end
    in_valid_i = 1; in_rd_i = 5'd5; #1;
    checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL exhaust_ready_rd got %0d exp 0", in_ready_o); end
    in_rd_i = 5'd0; #1;
    checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL exhaust_ready_rd0 got %0d exp 1", in_ready_o); end
    in_valid_i = 0;
    commit(6'd0);
    checks++; if (free_count_o !== 7'd0) begin errors++; $display("FAIL commit_pr0 got %0d exp 0", free_count_o); end
    commit(6'd40);
    checks++; if (free_count_o !== 7'd1) begin errors++; $display("FAIL commit40_count got %0d exp 1", free_count_o); end
    rename(5'd3, 5'd0, 5'd0, 1'b0);
    checks++; if (out_valid_o !== 1'b1 || out_rd_o !== 6'd40) begin
      errors++; $display("FAIL realloc40 got v=%0d rd=%0d exp 1 40", out_valid_o, out_rd_o); end
  endtask

  task automatic test_rollback();
    do_reset();
    rename(5'd5, 5'd0, 5'd0, 1'b1);
    checks++; if (out_rd_o !== 6'd32 || out_ckpt_id_o !== 2'd0) begin
      errors++; $display("FAIL rb_ckpt got rd=%0d id=%0d exp 32 0", out_rd_o, out_ckpt_id_o); end
    rename(5'd5, 5'd0, 5'd0, 1'b0);
    checks++; if (out_rd_o !== 6'd33 || out_prev_rd_o !== 6'd32) begin
      errors++; $display("FAIL rb_second got rd=%0d prev=%0d exp 33 32", out_rd_o, out_prev_rd_o); end
    rename(5'd9, 5'd0, 5'd0, 1'b0);
    checks++; if (out_rd_o !== 6'd34 || free_count_o !== 7'd29) begin
      errors++; $display("FAIL rb_third got rd=%0d free=%0d exp 34 29", out_rd_o, free_count_o); end
    do_restore(2'd0, 6'd0);
    checks++; if (free_count_o !== 7'd31) begin errors++; $display("FAIL rb_free_count got %0d exp 31", free_count_o); end
    rename(5'd5, 5'd9, 5'd5, 1'b0);
    checks++; if (out_rs1_o !== 6'd9 || out_rs2_o !== 6'd32 || out_rd_o !== 6'd33 || out_prev_rd_o !== 6'd32) begin
      errors++; $display("FAIL rb_map got rs1=%0d rs2=%0d rd=%0d prev=%0d exp 9 32 33 32",
                         out_rs1_o, out_rs2_o, out_rd_o, out_prev_rd_o); end
  endtask

  task automatic test_restore_commit();
    do_reset();
    rename(5'd5, 5'd0, 5'd0, 1'b1);
    rename(5'd6, 5'd0, 5'd0, 1'b0);
    commit(6'd6);
    checks++; if (free_count_o !== 7'd31) begin errors++; $display("FAIL rc_pre got %0d exp 31", free_count_o); end
    do_restore(2'd0, 6'd5);
    checks++; if (free_count_o !== 7'd33) begin errors++; $display("FAIL rc_free_count got %0d exp 33", free_count_o); end
    rename(5'd1, 5'd0, 5'd0, 1'b0);
    checks++; if (out_rd_o !== 6'd5) begin errors++; $display("FAIL rc_alloc5 got %0d exp 5", out_rd_o); end
    rename(5'd2, 5'd0, 5'd0, 1'b0);
    checks++; if (out_rd_o !== 6'd6) begin errors++; $display("FAIL rc_alloc6 got %0d exp 6", out_rd_o); end
  endtask

  task automatic test_fifo_full();
    do_reset();
    do_release();
    for (int i = 0; i < 4; i++) begin
      rename(5'(i + 1), 5'd0, 5'd0, 1'b1);
      checks++; if (out_ckpt_id_o !== 2'(i)) begin errors++; $display("FAIL ff_id%0d got %0d exp %0d", i, out_ckpt_id_o, i); end
    end
    checks++; if (ckpt_full_o !== 1'b1) begin errors++; $display("FAIL ff_full got %0d exp 1", ckpt_full_o); end
    in_valid_i = 1; in_rd_i = 5'd5; in_ckpt_i = 1; #1;
    checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL ff_stall got %0d exp 0", in_ready_o); end
    in_ckpt_i = 0; #1;
    checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL ff_nockpt_ready got %0d exp 1", in_ready_o); end
    in_valid_i = 0;
    do_release();
    checks++; if (ckpt_full_o !== 1'b0) begin errors++; $display("FAIL ff_release got %0d exp 0", ckpt_full_o); end
    rename(5'd6, 5'd0, 5'd0, 1'b1);
    checks++; if (out_ckpt_id_o !== 2'd0 || ckpt_full_o !== 1'b1) begin
      errors++; $display("FAIL ff_wrap got id=%0d full=%0d exp 0 1", out_ckpt_id_o, ckpt_full_o); end
    do_release();
    release_i = 1; live[head_m] = 1'b0; head_m = head_m + 2'd1;
    rename(5'd7, 5'd0, 5'd0, 1'b1);
    release_i = 0;
    checks++; if (out_ckpt_id_o !== 2'd1 || ckpt_full_o !== 1'b0) begin
      errors++; $display("FAIL ff_take_release got id=%0d full=%0d exp 1 0", out_ckpt_id_o, ckpt_full_o); end
    rename(5'd8, 5'd0, 5'd0, 1'b1);
    checks++; if (out_ckpt_id_o !== 2'd2 || ckpt_full_o !== 1'b1) begin
      errors++; $display("FAIL ff_refill got id=%0d full=%0d exp 2 1", out_ckpt_id_o, ckpt_full_o); end
  endtask

  task automatic test_reset_mid();
    rst_i = 1; in_valid_i = 1; in_rd_i = 5'd9;
    @(posedge clk_i); #1;
    rst_i = 0; in_valid_i = 0;
    live = 0; head_m = 0; tail_m = 0;
    checks++; if (out_valid_o !== 1'b0 || free_count_o !== 7'd32 || ckpt_full_o !== 1'b0) begin
      errors++; $display("FAIL mid_reset got v=%0d free=%0d full=%0d exp 0 32 0",
                         out_valid_o, free_count_o, ckpt_full_o); end
    rename(5'd4, 5'd4, 5'd0, 1'b0);
    checks++; if (out_rd_o !== 6'd32 || out_rs1_o !== 6'd4 || out_prev_rd_o !== 6'd4) begin
      errors++; $display("FAIL mid_reset_rename got rd=%0d rs1=%0d prev=%0d exp 32 4 4",
                         out_rd_o, out_rs1_o, out_prev_rd_o); end
  endtask

  initial begin
    rst_i = 1; clear_inputs();
    live = 0; head_m = 0; tail_m = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_exhaust();
    test_rollback();
    test_restore_commit();
    test_fifo_full();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
